// File: rtl/rmii_rx_pkg.sv
// Shared types and constants for the RMII receive framer.
// The CRC constants are used only when RMII_RX_CRC_CHECK_EN is defined.
package rmii_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam int ST_RX_ER = 0;
    localparam int ST_ALIGN = 1;
    localparam int ST_SHORT = 2;
    localparam int ST_LONG  = 3;
    localparam int ST_CRC   = 4;
    localparam int ST_W     = 5;

    localparam int LEN_W = 11;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam int DEF_MIN_LEN = 64;
    localparam int DEF_MAX_LEN = 1518;

endpackage

// File: rtl/rmii_crc32_byte.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
// Instantiated by the framer only when RMII_RX_CRC_CHECK_EN is defined.
module rmii_crc32_byte
    import rmii_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0]) begin
                crc_next = (crc_next >> 1) ^ CRC32_POLY;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD hunt, dibit-to-byte assembly, frame status.
// Define RMII_RX_CRC_CHECK_EN to build the FCS check (status bit 4).
module rmii_rx_framer
    import rmii_rx_pkg::*;
#(
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            crs_dv,
    input  logic [1:0]      rx_d,
    input  logic            rx_er,
    output logic [7:0]      m_data,
    output logic            m_valid,
    output logic            m_last,
    output logic [ST_W-1:0] m_status,
    output logic [15:0]     stat_ok,
    output logic [15:0]     stat_bad
);

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t state;
    state_t state_n;

    logic             pre_seen;
    logic             drop_lo;
    logic [1:0]       idx;
    logic [7:0]       shreg;
    logic [7:0]       hold;
    logic             hold_vld;
    logic [LEN_W-1:0] len;
    logic             er_flag;

    logic             pre_set;
    logic             pre_clr;
    logic             enter_data;
    logic             shift_en;
    logic             frame_end;
    logic             byte_done;
    logic [7:0]       new_byte;
    logic [LEN_W-1:0] len_inc;
    logic [ST_W-1:0]  status;

    assign new_byte  = {rx_d, shreg[7:2]};
    assign byte_done = shift_en && (idx == 2'd3);
    assign len_inc   = (len == '1) ? len : len + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        pre_set    = 1'b0;
        pre_clr    = 1'b0;
        enter_data = 1'b0;
        shift_en   = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (crs_dv) begin
                    state_n = S_PREAMBLE;
                    pre_clr = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (!crs_dv) begin
                    state_n = S_IDLE;
                end else if (rx_d == 2'b01) begin
                    pre_set = 1'b1;
                end else if (rx_d == 2'b11) begin
                    if (pre_seen) begin
                        state_n    = S_DATA;
                        enter_data = 1'b1;
                    end else begin
                        state_n = S_DROP;
                    end
                end else if (rx_d == 2'b10) begin
                    state_n = S_DROP;
                end
            end
            S_DATA: begin
                // Low CRS_DV on odd dibits is the post-carrier toggle
                if (!crs_dv && !idx[0]) begin
                    frame_end = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    shift_en = 1'b1;
                end
            end
            S_DROP: begin
                if (!crs_dv && drop_lo) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef RMII_RX_CRC_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_nx;

    rmii_crc32_byte u_crc (
        .crc      (crc),
        .data     (new_byte),
        .crc_next (crc_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC32_INIT;
        end else if (enter_data) begin
            crc <= CRC32_INIT;
        end else if (byte_done) begin
            crc <= crc_nx;
        end
    end
`endif

    always_comb begin
        status            = '0;
        status[ST_RX_ER]  = er_flag | rx_er;
        status[ST_ALIGN]  = (idx == 2'd2);
        status[ST_SHORT]  = (len < MIN_L);
        status[ST_LONG]   = (len > MAX_L);
`ifdef RMII_RX_CRC_CHECK_EN
        status[ST_CRC]    = (crc != CRC32_RESIDUE);
`else
        status[ST_CRC]    = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_seen <= 1'b0;
            drop_lo  <= 1'b0;
        end else begin
            drop_lo <= (state == S_DROP) && !crs_dv;
            if (pre_clr) begin
                pre_seen <= 1'b0;
            end else if (pre_set) begin
                pre_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            shreg    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            len      <= '0;
            er_flag  <= 1'b0;
        end else if (enter_data) begin
            idx      <= '0;
            shreg    <= '0;
            hold_vld <= 1'b0;
            len      <= '0;
            er_flag  <= 1'b0;
        end else if (shift_en) begin
            shreg <= new_byte;
            idx   <= idx + 2'd1;
            if (rx_er) begin
                er_flag <= 1'b1;
            end
            if (byte_done) begin
                hold     <= new_byte;
                hold_vld <= 1'b1;
                len      <= len_inc;
            end
        end else if (frame_end) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_status <= '0;
            stat_ok  <= '0;
            stat_bad <= '0;
        end else begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_status <= '0;
            // The held byte goes out once its successor is complete
            if (byte_done && hold_vld) begin
                m_data  <= hold;
                m_valid <= 1'b1;
            end
            if (frame_end && hold_vld) begin
                m_data   <= hold;
                m_valid  <= 1'b1;
                m_last   <= 1'b1;
                m_status <= status;
                if (status == '0) begin
                    stat_ok <= stat_ok + 16'd1;
                end else begin
                    stat_bad <= stat_bad + 16'd1;
                end
            end
        end
    end

endmodule
